// File: rtl/window_gen.sv
// Sliding 5x5 window generator over a raster-order pixel stream.
// Four line buffers hold the previous rows. A 5x5 shift register forms the
// window. A separate output register presents completed windows downstream
// with valid/ready handshaking.
module window_gen #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_pix,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [199:0] win_out,
  output logic         out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(4);
  localparam logic [RW-1:0] ROW_FULL = RW'(4);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [199:0]   win_out_q, win_out_d;
  logic [199:0]   win_q, win_d;

  // lb_q[0] holds the row directly above the current one; lb_q[3] holds the row four above.
  logic [7:0]     lb_q [4][IMG_W];
  logic [7:0]     col_pix [5];

  logic           accept;
  logic           produce;
  logic           at_row_end;
  logic           at_frame_end;

  // Handshake: accept a pixel only when any pending window can drain this cycle.
  always_comb begin
    in_ready     = !rst && (!out_valid_q || out_ready);
    accept       = in_valid && in_ready;
    at_row_end   = (col_q == COL_MAX);
    at_frame_end = at_row_end && (row_q == ROW_MAX);
    produce      = accept && (row_q >= ROW_FULL) && (col_q >= COL_FULL);
  end

  // Build the new rightmost window column and shift the window left on acceptance.
  always_comb begin
    col_pix[0] = lb_q[3][col_q];
    col_pix[1] = lb_q[2][col_q];
    col_pix[2] = lb_q[1][col_q];
    col_pix[3] = lb_q[0][col_q];
    col_pix[4] = in_pix;
    win_d      = win_q;
    if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[(r*5+c)*8 +: 8] = win_q[(r*5+c+1)*8 +: 8];
        end
        win_d[(r*5+4)*8 +: 8] = col_pix[r];
      end
    end
  end

  // Next-state for the raster counters and the output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    win_out_d   = win_out_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept) begin
      if (at_row_end) begin
        col_d = '0;
        row_d = at_frame_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (produce) begin
      out_valid_d = 1'b1;
      out_last_d  = at_frame_end;
      win_out_d   = win_d;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_out_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_out_q   <= win_out_d;
    end
  end

  // Pixel storage is never reset; a window is only published once every element is from this frame.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (accept) begin
      lb_q[3][col_q] <= lb_q[2][col_q];
      lb_q[2][col_q] <= lb_q[1][col_q];
      lb_q[1][col_q] <= lb_q[0][col_q];
      lb_q[0][col_q] <= in_pix;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign win_out   = win_out_q;

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard testbench for window_gen at the default 32x32 image size.
module tb_window_gen;

  localparam int W = 32;
  localparam int H = 32;
  localparam int WINDOWS = (W - 4) * (H - 4);

  typedef struct packed {
    logic [199:0] win;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_pix;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [199:0] win_out;
  logic         out_last;

  int   checksPassed = 0;
  int   checksTotal  = 0;
  int   winCount     = 0;
  int   lastCount    = 0;
  int   readyMode    = 0;
  exp_t sbQ[$];

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win_out   (win_out),
    .out_last  (out_last)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its required value and record the outcome.
  task automatic checkOutput(input string name, input logic [199:0] actual, input logic [199:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Test image patterns: 0 is the ramp, 1 varies across all rows so row aliasing shows.
  function automatic logic [7:0] pixel(input int pat, input int r, input int c);
    int v;
    if (pat == 0) v = (r * 32 + c) & 255;
    else          v = (r * 5 + c * 11 + 3) & 255;
    return 8'(v);
  endfunction

  // Expected window for the pixel accepted at (row, col).
  function automatic logic [199:0] expWin(input int pat, input int row, input int col);
    logic [199:0] w;
    w = '0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < 5; cc++) begin
        w[(rr*5+cc)*8 +: 8] = pixel(pat, row - 4 + rr, col - 4 + cc);
      end
    end
    return w;
  endfunction

  // Drive one frame (or part of one) and push each expected window as its pixel is accepted.
  task automatic applyStimulus(input int pat, input bit gaps, input bit latCheck, input int nPix);
    int   row = 0;
    int   col = 0;
    bit   prevProduce = 1'b0;
    bit   havePrev = 1'b0;
    int   prevIdx = 0;
    bit   accepted;
    int   waitCycles;
    int   idle;
    exp_t e;
    for (int p = 0; p < nPix; p++) begin
      if (gaps) begin
        idle = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (idle) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid   = 1'b1;
      in_pix     = pixel(pat, row, col);
      accepted   = 1'b0;
      waitCycles = 0;
      while (!accepted) begin
        @(negedge clk);
        if (latCheck && havePrev && waitCycles == 0) begin
          checkOutput("latency_out_valid", out_valid, prevProduce);
          if (pat == 0 && prevIdx == 132) begin
            checkOutput("first_elem0",  win_out[7:0],     8'd0);
            checkOutput("first_elem4",  win_out[39:32],   8'd4);
            checkOutput("first_elem20", win_out[167:160], 8'd128);
            checkOutput("first_elem24", win_out[199:192], 8'd132);
          end
        end
        if (in_ready) begin
          accepted = 1'b1;
          if (row >= 4 && col >= 4) begin
            e.win  = expWin(pat, row, col);
            e.last = (row == H - 1) && (col == W - 1);
            sbQ.push_back(e);
          end
        end else begin
          waitCycles++;
          if (waitCycles > 1000) begin
            checksTotal++;
            $display("[TB] FAIL accept_timeout: pixel %0d not accepted, required acceptance within 1000 cycles", p);
            in_valid = 1'b0;
            return;
          end
        end
        @(posedge clk);
        #1;
      end
      prevProduce = (row >= 4 && col >= 4);
      havePrev    = 1'b1;
      prevIdx     = p;
      if (col == W - 1) begin
        col = 0;
        row = (row == H - 1) ? 0 : row + 1;
      end else begin
        col++;
      end
    end
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then check the frame totals.
  task automatic drainFrame(input string tag);
    int n = 0;
    while (sbQ.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_pending"}, 200'(sbQ.size()), 200'd0);
    checkOutput({tag, "_windows"}, 200'(winCount), 200'(WINDOWS));
    checkOutput({tag, "_last_count"}, 200'(lastCount), 200'd1);
  endtask

  // Downstream ready generator: 0 always ready, 1 six-cycle stalls, 2 random, 3 held low.
  initial begin
    int stallLeft = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: out_ready = 1'b1;
        1: begin
          if (stallLeft > 0) begin
            out_ready = 1'b0;
            stallLeft--;
          end else if (out_valid && $urandom_range(0, 15) == 0) begin
            out_ready = 1'b0;
            stallLeft = 5;
          end else begin
            out_ready = 1'b1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare on every handshake, and check holding behaviour during stalls.
  initial begin
    exp_t         e;
    bit           lastStalled = 1'b0;
    logic [199:0] lastWin = '0;
    logic         lastLast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lastStalled = 1'b0;
      end else if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checksTotal++;
          $display("[TB] FAIL unexpected_window: got window %h, required no window", win_out);
        end else begin
          e = sbQ.pop_front();
          checkOutput("window", win_out, e.win);
          checkOutput("out_last", out_last, e.last);
          winCount++;
          if (out_last) lastCount++;
        end
        lastStalled = 1'b0;
      end else if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 1'b0);
        if (lastStalled) begin
          checkOutput("stall_win_hold", win_out, lastWin);
          checkOutput("stall_last_hold", out_last, lastLast);
        end
        lastStalled = 1'b1;
        lastWin     = win_out;
        lastLast    = out_last;
      end else begin
        lastStalled = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at 2 ms, required completion");
    $display("%0d/%0d checks passed", checksPassed, checksTotal + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pix   = 8'hAA;

    @(negedge clk);
    checkOutput("reset_out_valid_1", out_valid, 1'b0);
    checkOutput("reset_win_out_1", win_out, 200'd0);
    checkOutput("reset_in_ready_1", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("reset_out_valid_2", out_valid, 1'b0);
    checkOutput("reset_win_out_2", win_out, 200'd0);
    checkOutput("reset_out_last_2", out_last, 1'b0);
    checkOutput("reset_in_ready_2", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] frame 1: continuous ramp");
    readyMode = 0; winCount = 0; lastCount = 0;
    applyStimulus(0, 1'b0, 1'b1, W * H);
    drainFrame("ramp");

    $display("[TB] frame 2: six-cycle backpressure stalls");
    readyMode = 1; winCount = 0; lastCount = 0;
    applyStimulus(1, 1'b0, 1'b0, W * H);
    readyMode = 0;
    drainFrame("stall");

    $display("[TB] frame 3: random input gaps and random ready");
    readyMode = 2; winCount = 0; lastCount = 0;
    applyStimulus(1, 1'b1, 1'b0, W * H);
    readyMode = 0;
    drainFrame("random");

    $display("[TB] mid-frame reset after 500 pixels");
    readyMode = 0;
    applyStimulus(1, 1'b0, 1'b0, 500);
    readyMode = 3;
    repeat (2) @(posedge clk);
    #1;
    sbQ.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_out_last", out_last, 1'b0);
    checkOutput("midreset_win_out", win_out, 200'd0);
    readyMode = 0; winCount = 0; lastCount = 0;
    applyStimulus(0, 1'b0, 1'b1, W * H);
    drainFrame("after_reset");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 The parameter list SHALL be IMG_W, default 32, input image width in pixels; minimum 5.
REQ-002 The parameter list SHALL be IMG_H, default 32, input image height in rows; minimum 5.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  pixel present on in_pix.
REQ-006 The block SHALL have port in_pix  input  8  unsigned pixel, raster order (row-major, top-left first).
REQ-007 The block SHALL have port in_ready  output  1  block can accept a pixel this cycle.
REQ-008 The block SHALL have port out_valid  output  1  win_out holds a complete 5x5 window.
REQ-009 The block SHALL have port out_ready  input  1  downstream PE accepts the window this cycle.
REQ-010 The block SHALL have port win_out  output  200  window; element k=r*5+c at bits [8k+7:8k], r=0 top row, c=0 left column; k maps to PE operand in_IF(k+1).
REQ-011 The block SHALL have port out_last  output  1  qualifies the final window of a frame.

Function
REQ-012 A pixel SHALL be accepted in a cycle if and only if in_valid && in_ready.
REQ-013 in_ready SHALL be combinational: !rst && (!out_valid || out_ready).
REQ-014 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) holding the position of the next pixel to be accepted; both SHALL advance only on acceptance.
REQ-015 Column wrap: on acceptance at col=IMG_W-1, col SHALL go to 0 and row SHALL increment.
REQ-016 Frame wrap: on acceptance at (IMG_H-1, IMG_W-1), row and col SHALL go to 0, and the next pixel SHALL be treated as pixel (0,0) of a new frame.
REQ-017 The block SHALL hold four line buffers of IMG_W x 8 bits, containing the previous four rows, plus a 5x5 shift-register window.
REQ-018 On acceptance of pixel (row,col), the window SHALL shift one column left and load column c=4 with pixels (row-4..row, col), where r=4 is in_pix.
REQ-019 A window SHALL be produced on acceptance when row>=4 && col>=4; element (r,c) SHALL then equal pixel(row-4+r, col-4+c).
REQ-020 Latency: win_out and out_valid SHALL update on the clock edge that accepts the producing pixel, so they are visible the following cycle.
REQ-021 out_last SHALL be 1 exactly with the window produced at (IMG_H-1, IMG_W-1), and SHALL be 0 otherwise.
REQ-022 out_valid SHALL rise on a producing acceptance; it SHALL fall after out_valid && out_ready when no new window is produced in the same cycle.
REQ-023 If the current window is consumed and a new window is produced in the same cycle, out_valid SHALL stay 1 and win_out SHALL update.
REQ-024 Stall: while out_valid && !out_ready, in_ready SHALL be 0, and win_out, out_last, the counters and the line buffers SHALL hold.
REQ-025 Acceptances with row<4 or col<4 SHALL update the line buffers and the window without asserting out_valid.
REQ-026 Per frame, the block SHALL emit exactly (IMG_W-4)*(IMG_H-4) windows (784 at the defaults), in raster order.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_last=0, win_out=0, row=0 and col=0; in_ready SHALL read 0 during rst.
REQ-028 Line-buffer and window storage SHALL NOT be reset; stale contents SHALL never reach a valid output because of REQ-019.
REQ-029 A reset mid-frame SHALL discard the partial frame and any pending window; the first pixel accepted after reset SHALL be pixel (0,0).

Verification
REQ-030 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, win_out=0, in_ready=0; after release, in_ready=1 and no window appears before 133 acceptances.
REQ-031 Ramp frame: in_pix=(row*32+col)&0xFF, in_valid=1, out_ready=1 -> first out_valid one cycle after accepting pixel 132; that window has element0=0, element4=4, element20=128, element24=132; 784 windows total; out_last only on the last window.
REQ-032 Row wrap: after the window at (4,31), the next out_valid SHALL occur only after accepting (5,4); none for cols 0..3 of row 5.
REQ-033 Backpressure: out_ready=0 for 6 cycles while out_valid=1 -> in_ready=0 and win_out stable; the released window sequence SHALL be identical to the unstalled run.
REQ-034 Random in_valid gaps with random out_ready -> window sequence and out_last position SHALL match the continuous-stream run bit-exactly.
REQ-035 rst=1 for one cycle after 500 accepted pixels, then a fresh ramp frame -> first window after the 133rd new acceptance, element0=0, element24=132.
